// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
//
// Time-multiplexed FIR filter controller. A single signed multiplier and one
// wide accumulator are shared across all NTAPS taps. Each accepted sample is
// written into a circular delay line. One product per cycle is then
// accumulated, walking the taps from the newest sample (tap 0) back to the
// oldest. The scaled and saturated sum is presented on a valid/ready output.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-low reset
//   in_valid   input sample valid
//   in_data    signed input sample (DW bits)
//   in_ready   block can accept a sample (high only in IDLE)
//   out_valid  filtered result valid (high only in OUT)
//   out_data   signed filtered result (DW bits), held while stalled
//   out_ready  downstream accepts the result
//   coef_we    coefficient write strobe (honoured only in IDLE)
//   coef_addr  coefficient index k
//   coef_data  signed coefficient value (CW bits)
//   busy       high while in MAC or OUT
module fir_mac_sequencer #(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int NTAPS = 8,
  parameter int SHIFT = 15,
  parameter int AW    = $clog2(NTAPS),
  parameter int ACCW  = DW + CW + AW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_data,
  input  logic                 out_ready,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Saturation bounds expressed at accumulator width so the comparison is
  // done on the full shifted value before truncation.
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

  state_t state;
  state_t state_next;

  logic [AW-1:0] tap_idx;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_addr;

  logic signed [DW-1:0] delay_line [NTAPS];
  logic signed [CW-1:0] coef       [NTAPS];

  logic signed [CW-1:0]      coef_rd;
  logic signed [DW-1:0]      sample_rd;
  logic signed [DW+CW-1:0]   coef_ext;
  logic signed [DW+CW-1:0]   sample_ext;
  logic signed [DW+CW-1:0]   product;
  logic signed [ACCW-1:0]    acc;
  logic signed [ACCW-1:0]    acc_sum;
  logic signed [ACCW-1:0]    acc_shifted;
  logic signed [DW-1:0]      sat_value;

  logic sample_take;
  logic last_tap;

  assign sample_take = in_valid && in_ready;
  assign last_tap    = (tap_idx == AW'(NTAPS - 1));

  // Tap 0 pairs with the newest sample at wr_ptr. Higher taps walk backwards
  // through the delay line. The AW-bit subtraction wraps modulo NTAPS for
  // free because NTAPS is a power of two.
  assign rd_addr   = wr_ptr - tap_idx;
  assign coef_rd   = coef[tap_idx];
  assign sample_rd = delay_line[rd_addr];

  // Both operands are sign-extended to the full product width so the
  // multiply is done at one width and keeps full precision.
  assign coef_ext   = {{DW{coef_rd[CW-1]}}, coef_rd};
  assign sample_ext = {{CW{sample_rd[DW-1]}}, sample_rd};
  assign product    = coef_ext * sample_ext;

  assign acc_sum     = acc + {{AW{product[DW+CW-1]}}, product};
  assign acc_shifted = acc_sum >>> SHIFT;

  // The result register is loaded on the final MAC edge. It therefore
  // saturates the sum that includes the last product, not the stale acc.
  always_comb begin
    sat_value = acc_shifted[DW-1:0];
    if (acc_shifted > SAT_MAX) begin
      sat_value = SAT_MAX[DW-1:0];
    end else if (acc_shifted < SAT_MIN) begin
      sat_value = SAT_MIN[DW-1:0];
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (sample_take) begin
          state_next = MAC;
        end
      end
      MAC: begin
        if (last_tap) begin
          state_next = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs (Moore, decoded from the registered state)
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
      end
      MAC: begin
        busy = 1'b1;
      end
      OUT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Datapath: delay line, coefficient bank, accumulator, tap/pointer
  // counters and the output holding register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc      <= '0;
      tap_idx  <= '0;
      wr_ptr   <= '0;
      out_data <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        delay_line[i] <= '0;
        coef[i]       <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          // A write that coincides with a handshake still commits here.
          // The MAC pass starts next cycle and sees the new value.
          if (coef_we) begin
            coef[coef_addr] <= coef_data;
          end
          if (sample_take) begin
            delay_line[wr_ptr] <= in_data;
            acc                <= '0;
            tap_idx            <= '0;
          end
        end
        MAC: begin
          acc     <= acc_sum;
          tap_idx <= tap_idx + AW'(1);
          if (last_tap) begin
            out_data <= sat_value;
          end
        end
        OUT: begin
          // wr_ptr advances only once the result is consumed, so the
          // pass still points at the sample it was computed from.
          if (out_ready) begin
            wr_ptr <= wr_ptr + AW'(1);
          end
        end
        default: begin
          acc <= acc;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer
//
// Directed bench for fir_mac_sequencer with NTAPS=4 and SHIFT=0. A small
// reference model tracks coefficients and the last four samples. Each driven
// sample pushes its expected filtered value onto a scoreboard queue. That
// value is popped and compared when the DUT presents its result.
module tb_fir_mac_sequencer;

  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int NTAPS = 4;
  localparam int SHIFT = 0;
  localparam int AW    = 2;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [CW-1:0] coef_data;
  logic          busy;

  int nAsserts = 0;
  int nFails   = 0;
  int cycleCount = 0;
  int hsEdge = 0;

  logic [CW-1:0] mcoef [NTAPS];
  logic [DW-1:0] hist  [NTAPS];
  logic [DW-1:0] expQ  [$];

  fir_mac_sequencer #(
    .DW(DW), .CW(CW), .NTAPS(NTAPS), .SHIFT(SHIFT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .coef_we(coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DW-1:0] modelOut();
    longint sum;
    logic [63:0] bits;
    sum = 0;
    for (int k = 0; k < NTAPS; k++) begin
      sum += longint'($signed(mcoef[k])) * longint'($signed(hist[k]));
    end
    sum = sum >>> SHIFT;
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    bits = sum;
    return bits[DW-1:0];
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clearModel();
    for (int k = 0; k < NTAPS; k++) begin
      mcoef[k] = '0;
      hist[k]  = '0;
    end
    expQ.delete();
  endtask

  task automatic writeCoef(input logic [AW-1:0] addr, input logic [CW-1:0] data,
                           input bit expectTaken);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_data = data;
    @(negedge clk);
    coef_we = 1'b0;
    if (expectTaken) mcoef[addr] = data;
  endtask

  // Drives one sample, optionally with a coefficient write in the same
  // cycle. Returns at the negedge just after the handshake edge.
  task automatic applyStimulus(input logic [DW-1:0] sample, input logic we,
                               input logic [AW-1:0] addr, input logic [CW-1:0] data);
    int n;
    n = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = sample;
    coef_we   = we;
    coef_addr = addr;
    coef_data = data;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkValue("in_ready_timeout", (n >= 100), 0);
    if (we) mcoef[addr] = data;
    for (int k = NTAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = sample;
    expQ.push_back(modelOut());
    hsEdge = cycleCount + 1;
    @(negedge clk);
    in_valid = 1'b0;
    coef_we  = 1'b0;
  endtask

  // Latency is the number of rising edges from the handshake edge to the
  // first edge at which downstream samples out_valid high (NTAPS+1).
  task automatic checkOutput(input string tag, input bit checkLatency,
                             input int holdCycles);
    int n;
    logic [DW-1:0] expv;
    logic [DW-1:0] held;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkValue({tag, "_timeout"}, (n >= 100), 0);
    if (checkLatency) checkValue({tag, "_latency"}, cycleCount + 1 - hsEdge, NTAPS + 1);
    expv = 'x;
    if (expQ.size() > 0) expv = expQ.pop_front();
    checkValue({tag, "_data"}, out_data, expv);
    held = out_data;
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      checkValue({tag, "_hold_valid"}, out_valid, 1);
      checkValue({tag, "_hold_data"}, out_data, held);
      checkValue({tag, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkValue({tag, "_valid_drop"}, out_valid, 0);
    if (holdCycles > 0) checkValue({tag, "_in_ready_after"}, in_ready, 1);
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    clearModel();
    repeat (2) @(negedge clk);
    checkValue("reset_in_ready", in_ready, 1);
    checkValue("reset_out_valid", out_valid, 0);
    checkValue("reset_out_data", out_data, 0);
    checkValue("reset_busy", busy, 0);
    reset = 1'b1;

    $display("[TB] impulse response");
    for (int k = 0; k < NTAPS; k++) writeCoef(AW'(k), CW'(k + 1), 1);
    applyStimulus(16'd1, 1'b0, '0, '0);
    checkOutput("impulse0", 1, 0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(16'd0, 1'b0, '0, '0);
      checkOutput($sformatf("impulse%0d", i), 1, 0);
    end

    $display("[TB] saturation");
    writeCoef(0, 16'h7FFF, 1);
    for (int k = 1; k < NTAPS; k++) writeCoef(AW'(k), '0, 1);
    applyStimulus(16'h7FFF, 1'b0, '0, '0);
    checkOutput("sat_pos", 0, 0);
    applyStimulus(16'h8000, 1'b0, '0, '0);
    checkOutput("sat_neg", 0, 0);

    $display("[TB] backpressure");
    writeCoef(0, 16'd1, 1);
    applyStimulus(16'h1234, 1'b0, '0, '0);
    checkValue("mac_busy", busy, 1);
    checkValue("mac_in_ready", in_ready, 0);
    checkOutput("backpressure", 0, 10);

    $display("[TB] ignored coefficient write");
    writeCoef(0, 16'd2, 1);
    applyStimulus(16'd3, 1'b0, '0, '0);
    writeCoef(0, 16'd5, 0);
    checkOutput("ignored_cur", 0, 0);
    applyStimulus(16'd4, 1'b0, '0, '0);
    checkOutput("ignored_next", 0, 0);
    writeCoef(0, 16'd5, 1);
    applyStimulus(16'd1, 1'b0, '0, '0);
    checkOutput("idle_write", 0, 0);

    $display("[TB] wrap-around");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    clearModel();
    for (int k = 0; k < NTAPS; k++) writeCoef(AW'(k), 16'd1, 1);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(DW'(i), 1'b0, '0, '0);
      checkOutput($sformatf("wrap%0d", i), 0, 0);
    end

    $display("[TB] coefficient write with handshake");
    applyStimulus(16'd2, 1'b1, 2'd0, 16'd10);
    checkOutput("same_cycle_write", 0, 0);

    $display("[TB] reset mid-MAC");
    applyStimulus(16'd9, 1'b0, '0, '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkValue("midreset_out_valid", out_valid, 0);
    checkValue("midreset_in_ready", in_ready, 1);
    checkValue("midreset_busy", busy, 0);
    reset = 1'b1;
    clearModel();
    applyStimulus(16'd7, 1'b0, '0, '0);
    checkOutput("post_reset", 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
